// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory bus initiator: size codes,
// I/O-region select defaults, FSM encoding and load-extension helpers.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int         IO_SEL_HI_DEF  = 17;
    localparam logic [1:0] IO_SEL_VAL_DEF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] sz, input logic sgn);
        case (sz)
            SZ_B:    return {{24{sgn & d[7]}}, d[7:0]};
            SZ_H:    return {{16{sgn & d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_ctrl.sv
// Turns IF word fetches and LS byte/half/word accesses into byte-serial
// transactions on the memory bus, with HCI freeze and UART backpressure.
module mem_byte_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         IO_SEL_HI  = IO_SEL_HI_DEF,
    parameter logic [1:0] IO_SEL_VAL = IO_SEL_VAL_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    state_t      state;
    logic        is_if;
    logic [31:0] base;
    logic [2:0]  nbytes;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wbuf;
    logic [31:0] rbuf;
    logic [2:0]  issue_cnt;
    logic [2:0]  recv_cnt;
    logic        io_gap;
    logic        rdy_q;
    // [0]: read address on the bus this cycle, [1]: its byte is on mem_din this cycle
    logic [1:0]  vld_pipe;

    logic [2:0]  eff_issue;
    logic [31:0] rd_a;
    logic [31:0] wr_a;
    logic        wr_io;
    logic        ls_io;
    logic [7:0]  wbyte;
    logic [31:0] rbuf_nxt;

    // First edge after an HCI break restarts issue from the first uncaptured byte.
    assign eff_issue = rdy_q ? issue_cnt : recv_cnt;
    assign rd_a      = base + {29'b0, eff_issue};
    assign wr_a      = base + {29'b0, issue_cnt};
    assign wr_io     = (wr_a[IO_SEL_HI -: 2] == IO_SEL_VAL);
    assign ls_io     = (ls_addr[IO_SEL_HI -: 2] == IO_SEL_VAL);
    assign wbyte     = wbuf[{issue_cnt[1:0], 3'b000} +: 8];

    always_comb begin
        rbuf_nxt = rbuf;
        rbuf_nxt[{recv_cnt[1:0], 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            is_if     <= 1'b0;
            base      <= '0;
            nbytes    <= '0;
            size      <= SZ_B;
            sgn       <= 1'b0;
            wbuf      <= '0;
            rbuf      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            vld_pipe  <= '0;
            io_gap    <= 1'b0;
            rdy_q     <= 1'b1;
            mem_a     <= '0;
            mem_wr    <= 1'b0;
            mem_dout  <= '0;
            if_done   <= 1'b0;
            if_data   <= '0;
            ls_done   <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            rdy_q <= rdy_in;
            if (if_flush && is_if && state == ST_READ) begin
                state    <= ST_IDLE;
                mem_a    <= '0;
                vld_pipe <= '0;
            end else if (rdy_in) begin
                case (state)
                    ST_IDLE: begin
                        mem_a     <= '0;
                        mem_wr    <= 1'b0;
                        vld_pipe  <= '0;
                        issue_cnt <= '0;
                        recv_cnt  <= '0;
                        io_gap    <= 1'b0;
                        rbuf      <= '0;
                        if (ls_req) begin
                            is_if  <= 1'b0;
                            base   <= ls_addr;
                            nbytes <= size_bytes(ls_size);
                            size   <= ls_size;
                            sgn    <= ls_signed;
                            wbuf   <= ls_wdata;
                            if (ls_we) begin
                                state <= ST_WRITE;
                                if (!(ls_io && io_buffer_full)) begin
                                    mem_a     <= ls_addr;
                                    mem_wr    <= 1'b1;
                                    mem_dout  <= ls_wdata[7:0];
                                    issue_cnt <= 3'd1;
                                    io_gap    <= ls_io;
                                end
                            end else begin
                                state       <= ST_READ;
                                mem_a       <= ls_addr;
                                vld_pipe[0] <= 1'b1;
                                issue_cnt   <= 3'd1;
                            end
                        end else if (if_req && !if_flush) begin
                            is_if       <= 1'b1;
                            base        <= if_addr;
                            nbytes      <= 3'd4;
                            size        <= SZ_W;
                            sgn         <= 1'b0;
                            state       <= ST_READ;
                            mem_a       <= if_addr;
                            vld_pipe[0] <= 1'b1;
                            issue_cnt   <= 3'd1;
                        end
                    end
                    ST_READ: begin
                        vld_pipe[1] <= vld_pipe[0] & rdy_q;
                        if (eff_issue < nbytes) begin
                            mem_a       <= rd_a;
                            issue_cnt   <= eff_issue + 3'd1;
                            vld_pipe[0] <= 1'b1;
                        end else begin
                            mem_a       <= '0;
                            issue_cnt   <= eff_issue;
                            vld_pipe[0] <= 1'b0;
                        end
                        if (rdy_q && vld_pipe[1]) begin
                            rbuf     <= rbuf_nxt;
                            recv_cnt <= recv_cnt + 3'd1;
                            if (recv_cnt + 3'd1 == nbytes) begin
                                state    <= ST_DONE;
                                mem_a    <= '0;
                                vld_pipe <= '0;
                                if (is_if) begin
                                    if_data <= rbuf_nxt;
                                    if_done <= 1'b1;
                                end else begin
                                    ls_rdata <= load_ext(rbuf_nxt, size, sgn);
                                    ls_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_WRITE: begin
                        mem_a  <= '0;
                        mem_wr <= 1'b0;
                        io_gap <= 1'b0;
                        if (issue_cnt == nbytes) begin
                            state   <= ST_DONE;
                            ls_done <= 1'b1;
                        end else if (!io_gap && !(wr_io && io_buffer_full)) begin
                            // the UART full flag lags a byte, so each I/O byte is followed by an idle cycle
                            mem_a     <= wr_a;
                            mem_wr    <= 1'b1;
                            mem_dout  <= wbyte;
                            issue_cnt <= issue_cnt + 3'd1;
                            io_gap    <= wr_io;
                        end
                    end
                    default: begin
                        if_done <= 1'b0;
                        ls_done <= 1'b0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Bench for mem_byte_ctrl: synchronous byte RAM with an I/O window, directed
// scenarios plus randomized loads/stores against a byte-array reference model.
module tb_mem_byte_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [1:0]  ls_size = 2'b00;
    logic        ls_signed = 1'b0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int errors = 0;
    int checks = 0;
    int io_rd  = 0;

    logic [7:0]  bram [logic [31:0]];
    logic [7:0]  mref [logic [31:0]];
    logic [7:0]  io_q [$];
    logic [31:0] trace [$];

    mem_byte_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size), .ls_signed(ls_signed),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] init_b(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] bram_rd(input logic [31:0] a);
        return bram.exists(a) ? bram[a] : init_b(a);
    endfunction
    function automatic logic [7:0] mref_rd(input logic [31:0] a);
        return mref.exists(a) ? mref[a] : init_b(a);
    endfunction
    function automatic bit is_io(input logic [31:0] a);
        return a[17:16] == 2'b11;
    endfunction
    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction
    function automatic logic [31:0] exp_load(input logic [31:0] a, input int n, input bit sg);
        logic [31:0] v;
        v = 0;
        for (int k = 0; k < n; k++) v = v + (32'(mref_rd(a + 32'(k))) << (8 * k));
        if (sg && n == 1 && v >= 32'd128) v = v - 32'd256;
        if (sg && n == 2 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    // Memory bus: write on the edge, read data valid the cycle after the address.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) begin
                if (is_io(mem_a)) io_q.push_back(mem_dout);
                else bram[mem_a] = mem_dout;
            end else if (is_io(mem_a)) begin
                io_rd <= io_rd + 1;
            end
            mem_din <= mem_wr ? 8'h00 : bram_rd(mem_a);
        end else begin
            mem_din <= 8'($urandom);
        end
    end

    task automatic preset(input logic [31:0] a, input logic [7:0] b);
        bram[a] = b;
        mref[a] = b;
    endtask

    task automatic cyc1();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic txn(input bit is_if_t, input bit we, input logic [31:0] a, input logic [1:0] sz,
                       input bit sg, input logic [31:0] wd, input bit stall,
                       output logic [31:0] rd, output int cyc, output bit to);
        trace.delete();
        if (is_if_t) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_addr = a; ls_size = sz; ls_signed = sg; ls_wdata = wd;
        end
        cyc = 0; to = 1'b1; rd = '0;
        for (int c = 1; c <= 200; c++) begin
            cyc1();
            trace.push_back(mem_a);
            if (is_if_t ? if_done : ls_done) begin
                cyc = c; rd = is_if_t ? if_data : ls_rdata; to = 1'b0;
                break;
            end
            if (stall) rdy_in = ($urandom_range(0, 3) != 0);
        end
        if_req = 1'b0; ls_req = 1'b0; rdy_in = 1'b1;
        for (int c = 0; c < 20 && (if_done || ls_done); c++) cyc1();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) cyc1();
        checks++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_bus: mem_a=%h mem_wr=%b want 0/0", mem_a, mem_wr); end
        rst_in = 1'b0;
        cyc1();
        checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_dout: got %h want 00", mem_dout); end
        checks++; if (if_done !== 1'b0 || ls_done !== 1'b0) begin errors++; $display("FAIL reset_done: if=%b ls=%b want 0/0", if_done, ls_done); end
        checks++; if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin errors++; $display("FAIL reset_data: if=%h ls=%h want 0/0", if_data, ls_rdata); end
        checks++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin errors++; $display("FAIL idle_bus: mem_a=%h mem_wr=%b want 0/0", mem_a, mem_wr); end
    endtask

    task automatic test_word_load();
        logic [31:0] rd; int cyc; bit to;
        preset(32'h100, 8'h78); preset(32'h101, 8'h56); preset(32'h102, 8'h34); preset(32'h103, 8'h12);
        txn(1'b0, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 1'b0, rd, cyc, to);
        checks++; if (to) begin errors++; $display("FAIL word_load_timeout: no ls_done"); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (trace.size() < 5 || trace[k] !== 32'h100 + 32'(k)) begin
                errors++; $display("FAIL word_load_addr%0d: got %h want %h", k, (trace.size() > k) ? trace[k] : 32'hx, 32'h100 + 32'(k));
            end
        end
        checks++; if (trace.size() < 5 || trace[4] !== 32'h0) begin errors++; $display("FAIL word_load_idle: cycle 5 mem_a not 0"); end
        checks++; if (cyc !== 6) begin errors++; $display("FAIL word_load_cycle: got %0d want 6", cyc); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL word_load_data: got %h want 12345678", rd); end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; int cyc; bit to;
        preset(32'h200, 8'h80);
        txn(1'b0, 1'b0, 32'h200, 2'b00, 1'b1, 32'h0, 1'b0, rd, cyc, to);
        checks++; if (to || rd !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed: got %h want FFFFFF80", rd); end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL byte_signed_cycle: got %0d want 3", cyc); end
        txn(1'b0, 1'b0, 32'h200, 2'b00, 1'b0, 32'h0, 1'b0, rd, cyc, to);
        checks++; if (to || rd !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned: got %h want 00000080", rd); end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL byte_unsigned_cycle: got %0d want 3", cyc); end
        preset(32'h2FF, 8'h34); preset(32'h300, 8'h92);
        txn(1'b0, 1'b0, 32'h2FF, 2'b01, 1'b1, 32'h0, 1'b0, rd, cyc, to);
        checks++; if (to || rd !== 32'hFFFF9234) begin errors++; $display("FAIL half_misaligned_signed: got %h want FFFF9234", rd); end
    endtask

    task automatic test_io_store();
        logic [31:0] rd; int cyc; bit to; bit got;
        io_q.delete();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30000; ls_size = 2'b00; ls_signed = 1'b0;
        ls_wdata = 32'hDEADBE41; io_buffer_full = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc1();
            checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin errors++; $display("FAIL io_full_hold c%0d: mem_wr=%b mem_a=%h want 0/0", c, mem_wr, mem_a); end
            if (c == 5) io_buffer_full = 1'b0;
        end
        cyc1();
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41) begin
            errors++; $display("FAIL io_write: wr=%b a=%h d=%h want 1/30000/41", mem_wr, mem_a, mem_dout); end
        cyc1();
        checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin errors++; $display("FAIL io_gap: wr=%b a=%h want 0/0", mem_wr, mem_a); end
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ls_done) begin got = 1'b1; break; end
            cyc1();
        end
        ls_req = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL io_store_done: no ls_done"); end
        cyc1();
        checks++; if (io_q.size() != 1 || io_q[0] !== 8'h41) begin errors++; $display("FAIL io_store_once: %0d bytes, want one 41", io_q.size()); end
        io_q.delete();
        txn(1'b0, 1'b1, 32'h30000, 2'b01, 1'b0, 32'h00004342, 1'b0, rd, cyc, to);
        checks++; if (to || trace.size() < 3 || trace[0] !== 32'h30000 || trace[1] !== 32'h0 || trace[2] !== 32'h30001) begin
            errors++; $display("FAIL io_half_gap: addr sequence wrong (to=%b)", to); end
        checks++; if (io_q.size() != 2 || io_q[0] !== 8'h42 || io_q[1] !== 8'h43) begin
            errors++; $display("FAIL io_half_data: %0d bytes, want 42 43", io_q.size()); end
    endtask

    task automatic test_arbitration();
        int lc, ic; logic [31:0] lr, ir, el, ei; bit early;
        el = exp_load(32'h500, 4, 1'b0); ei = exp_load(32'h400, 4, 1'b0);
        lc = 0; ic = 0; lr = '0; ir = '0; early = 1'b0;
        trace.delete();
        if_req = 1'b1; if_addr = 32'h400;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500; ls_size = 2'b10; ls_signed = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            cyc1();
            trace.push_back(mem_a);
            if (if_done && lc == 0) early = 1'b1;
            if (ls_done && lc == 0) begin lc = c; lr = ls_rdata; ls_req = 1'b0; end
            if (if_done) begin ic = c; ir = if_data; if_req = 1'b0; break; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        cyc1();
        checks++; if (lc != 6 || early) begin errors++; $display("FAIL arb_ls_first: ls done cycle %0d want 6, if early=%b", lc, early); end
        checks++; if (lr !== el) begin errors++; $display("FAIL arb_ls_data: got %h want %h", lr, el); end
        checks++; if (trace.size() < 8 || trace[7] !== 32'h400) begin errors++; $display("FAIL arb_if_start: cycle 8 mem_a not 00000400"); end
        checks++; if (ic != 13) begin errors++; $display("FAIL arb_if_cycle: got %0d want 13", ic); end
        checks++; if (ir !== ei) begin errors++; $display("FAIL arb_if_data: got %h want %h", ir, ei); end
    endtask

    task automatic test_rdy_stall();
        logic [31:0] e, r; bit got;
        for (int k = 0; k < 4; k++) preset(32'h600 + 32'(k), 8'($urandom));
        e = exp_load(32'h600, 4, 1'b0);
        trace.delete(); got = 1'b0; r = '0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600; ls_size = 2'b10; ls_signed = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            cyc1();
            trace.push_back(mem_a);
            if (ls_done) begin got = 1'b1; r = ls_rdata; break; end
            if (c == 4) rdy_in = 1'b0;
            if (c == 7) rdy_in = 1'b1;
        end
        ls_req = 1'b0; rdy_in = 1'b1;
        cyc1();
        checks++; if (!got || r !== e) begin errors++; $display("FAIL stall_data: got %h want %h (done=%b)", r, e, got); end
        checks++; if (trace.size() < 9 || trace[3] !== 32'h603 || trace[5] !== 32'h603) begin errors++; $display("FAIL stall_frozen: bus not held at 00000603"); end
        checks++; if (trace.size() < 9 || trace[7] !== 32'h602 || trace[8] !== 32'h603) begin errors++; $display("FAIL stall_reissue: bytes 2,3 not re-issued after resume"); end
    endtask

    task automatic test_flush();
        bit bad_done, got, bad_bus; logic [31:0] r, e;
        e = exp_load(32'h710, 4, 1'b0);
        bad_done = 1'b0; got = 1'b0; r = '0;
        if_req = 1'b1; if_addr = 32'h700;
        for (int c = 1; c <= 40; c++) begin
            cyc1();
            if (if_done) bad_done = 1'b1;
            if (c == 3) if_flush = 1'b1;
            if (c == 4) begin
                checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL flush_bus: got %h want 0", mem_a); end
                if_flush = 1'b0; if_req = 1'b0;
                ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h710; ls_size = 2'b10; ls_signed = 1'b0;
            end
            if (ls_done) begin got = (c == 10); r = ls_rdata; break; end
        end
        ls_req = 1'b0;
        cyc1();
        checks++; if (bad_done) begin errors++; $display("FAIL flush_no_done: if_done=1 want 0"); end
        checks++; if (!got || r !== e) begin errors++; $display("FAIL flush_then_ls: data %h want %h, on cycle 10=%b", r, e, got); end
        bad_bus = 1'b0;
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h720;
        for (int c = 0; c < 3; c++) begin
            cyc1();
            if (mem_a !== 32'h0 || if_done !== 1'b0) bad_bus = 1'b1;
        end
        if_req = 1'b0; if_flush = 1'b0;
        cyc1();
        checks++; if (bad_bus) begin errors++; $display("FAIL flush_idle_ignore: fetch started while flushed"); end
    endtask

    task automatic test_random_ls();
        logic [31:0] a, wd, rd, ev; logic [1:0] sz; bit isf, we, sg, stall, to, bad; int n, cyc;
        for (int i = 0; i < 40; i++) begin
            stall = (i >= 24);
            isf = ($urandom_range(0, 4) == 0);
            we  = !isf && ($urandom_range(0, 1) == 1);
            a   = 32'h1000 + 32'($urandom_range(0, 4095));
            sz  = isf ? 2'b10 : 2'($urandom_range(0, 3));
            sg  = !isf && ($urandom_range(0, 1) == 1);
            wd  = $urandom;
            n   = nb(sz);
            ev  = exp_load(a, n, sg);
            txn(isf, we, a, sz, sg, wd, stall, rd, cyc, to);
            checks++;
            if (to) begin
                errors++; $display("FAIL rand%0d_timeout: no done", i);
            end else if (we) begin
                bad = 1'b0;
                for (int k = 0; k < n; k++) begin
                    mref[a + 32'(k)] = wd[8*k +: 8];
                    if (bram_rd(a + 32'(k)) !== mref[a + 32'(k)]) bad = 1'b1;
                end
                if (bad) begin errors++; $display("FAIL rand%0d_store: ram at %h differs from %0d bytes of %h", i, a, n, wd); end
            end else if (rd !== ev) begin
                errors++; $display("FAIL rand%0d_load: got %h want %h (a=%h sz=%0d s=%b if=%b)", i, rd, ev, a, sz, sg, isf);
            end
            if (!stall && !to) begin
                checks++;
                if (cyc != (we ? n + 1 : n + 2)) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", i, cyc, we ? n + 1 : n + 2); end
            end
        end
        checks++; if (io_rd != 0) begin errors++; $display("FAIL io_read_unrequested: got %0d want 0", io_rd); end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_word_load();
        test_load_ext();
        test_io_store();
        test_arbitration();
        test_rdy_stall();
        test_flush();
        test_random_ls();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
